// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: oversampling UART receiver. Start bit, DATA_WIDTH data bits LSB
// first, optional parity bit, one stop bit. Each bit is decided by a 2-of-3
// majority vote around its centre; the stop bit is judged early so the next
// frame's start edge can be caught even with a slightly fast transmitter.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BCNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                r_state;
  logic                  r_sync1, r_sync2;
  logic [PRESCALE_W-1:0] r_p, r_edge;
  logic [BCNT_W-1:0]     r_bit;
  logic                  r_par_en, r_par_typ, r_par_bad;
  logic                  r_s0, r_s1, r_s2;
  logic [DATA_WIDTH-1:0] r_shift, r_pdata;
  logic                  r_dv, r_pe, r_se;

  logic                  w_line;
  logic [PRESCALE_W-1:0] w_p_eff, w_mid, w_last;
  logic                  w_at_m1, w_at_mid, w_at_p1, w_at_last;
  logic                  w_vote, w_stp_bad, w_par_bad;

  // 2-of-3 majority of the three centre samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Expected parity bit: even parity is the XOR of the data, odd inverts it
  function automatic logic par_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Effective oversampling ratio: at least 4 and always even so mid is exact
  assign w_p_eff   = (Prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4)
                                                 : (Prescale & ~PRESCALE_W'(1));
  assign w_mid     = r_p >> 1;
  assign w_last    = r_p - PRESCALE_W'(1);
  assign w_line    = r_sync2;
  assign w_at_m1   = (r_edge == w_mid - PRESCALE_W'(1));
  assign w_at_mid  = (r_edge == w_mid);
  assign w_at_p1   = (r_edge == w_mid + PRESCALE_W'(1));
  assign w_at_last = (r_edge == w_last);
  // Third sample is the live line on the mid+1 edge itself (covers P=4,
  // where mid+1 is also the last edge, and the early stop decision)
  assign w_vote    = maj3(r_s0, r_s1, w_at_p1 ? w_line : r_s2);
  assign w_stp_bad = ~w_vote;
  assign w_par_bad = r_par_en & r_par_bad;

  assign P_DATA     = r_pdata;
  assign data_valid = r_dv;
  assign par_err    = r_pe;
  assign stp_err    = r_se;
  assign busy       = (r_state != IDLE);

  // Two-flop synchronizer; resets to idle-high so reset release is not a start
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM: bit timing, sampling, shifting, checking and result pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_p       <= PRESCALE_W'(4);
      r_edge    <= '0;
      r_bit     <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_par_bad <= 1'b0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_shift   <= '0;
      r_pdata   <= '0;
      r_dv      <= 1'b0;
      r_pe      <= 1'b0;
      r_se      <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;
      if (r_state != IDLE && r_state != DONE) begin
        r_edge <= w_at_last ? '0 : r_edge + PRESCALE_W'(1);
        if (w_at_m1)  r_s0 <= w_line;
        if (w_at_mid) r_s1 <= w_line;
        if (w_at_p1)  r_s2 <= w_line;
      end
      case (r_state)
        // A low line here is edge 0 of a start bit; configuration is frozen now
        IDLE, DONE: begin
          r_edge <= '0;
          r_bit  <= '0;
          if (!w_line) begin
            r_p       <= w_p_eff;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_par_bad <= 1'b0;
            r_edge    <= PRESCALE_W'(1);
            r_state   <= START;
          end else begin
            r_state <= IDLE;
          end
        end
        START: begin
          if (w_at_last) r_state <= w_vote ? IDLE : DATA;
        end
        DATA: begin
          if (w_at_last) begin
            r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
            r_bit   <= r_bit + BCNT_W'(1);
            if (r_bit == BCNT_W'(DATA_WIDTH - 1)) r_state <= r_par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (w_at_last) begin
            r_par_bad <= (w_vote != par_bit(r_shift, r_par_typ));
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_at_p1) begin
            r_se   <= w_stp_bad;
            r_pe   <= w_par_bad;
            r_dv   <= ~(w_stp_bad | w_par_bad);
            if (!(w_stp_bad | w_par_bad)) r_pdata <= r_shift;
            r_edge  <= '0;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
